chacha20_seq_ctrl: RTL

//  Avalon-MM slave that sequences the ChaCha20 core over N keystream blocks.

---
 rtl/chacha20_seq_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/chacha20_seq_ctrl.sv
// Avalon-MM sequencer that drives the ChaCha20 core through NBLOCKS ready/start/valid/ack handshakes.
// Optional per-phase watchdog enabled by defining CHACHA_SEQ_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no job running, waiting for a start command
// WAIT_RDY | waiting for core_ready, then pulse core_start
// RUN      | waiting for core_valid, then pulse core_ack
module chacha20_seq_ctrl #(
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        core_ready,
   input  logic        core_valid,
   output logic        core_start,
   output logic        core_ack,
   output logic        irq
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WAIT_RDY = 2'd1;
   localparam logic [1:0] RUN      = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] nblocks;
   logic [CNT_W-1:0] count;
   logic             irq_en;
   logic             done;
   logic             err;
   logic             timeout;
   logic             busy;
   logic             wr;
   logic             ctrl_wr;
   logic             stat_wr;
   logic             nblk_wr;
   logic             start_cmd;
   logic             abort_cmd;
   logic             last_blk;
   logic             wd_expired;
   logic [31:0]      rd_mux;
   logic             unused_ok;

   assign unused_ok  = &{1'b0, writedata[31:CNT_W]};

   assign busy       = (state != IDLE);
   assign wr         = chipselect & ~write_n;
   assign ctrl_wr    = wr & (address == 2'd0);
   assign stat_wr    = wr & (address == 2'd1);
   assign nblk_wr    = wr & (address == 2'd2);
   assign start_cmd  = ctrl_wr & writedata[0];
   assign abort_cmd  = ctrl_wr & writedata[1] & busy;
   assign last_blk   = ((count + 1'b1) == nblocks);

   // Strobes are combinational so they vanish the instant reset forces IDLE.
   assign core_start = (state == WAIT_RDY) & core_ready & ~abort_cmd;
   assign core_ack   = (state == RUN) & core_valid & ~abort_cmd;
   assign irq        = irq_en & (done | timeout);

`ifdef CHACHA_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd_cnt;
   logic            wd_load;

   // Reload on every entry to WAIT_RDY or RUN; terminal count is zero.
   assign wd_load    = core_start | (core_ack & ~last_blk) |
                       ((state == IDLE) & start_cmd & (nblocks != '0));
   assign wd_expired = busy & (wd_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt <= '0;
      end else if (wd_load) begin
         wd_cnt <= WD_LOAD;
      end else if (busy && wd_cnt != '0) begin
         wd_cnt <= wd_cnt - 1'b1;
      end
   end
`else
   assign wd_expired = 1'b0;
   assign timeout    = 1'b0;
`endif

   always_comb begin
      rd_mux = '0;
      case (address)
         2'd0:    rd_mux[3:2]       = {busy, irq_en};
         2'd1:    rd_mux[3:0]       = {err, timeout, done, busy};
         2'd2:    rd_mux[CNT_W-1:0] = nblocks;
         default: rd_mux[CNT_W-1:0] = count;
      endcase
   end

`ifdef CHACHA_SEQ_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timeout <= 1'b0;
      end else begin
         if (stat_wr && writedata[2])
            timeout <= 1'b0;
         if (busy && !abort_cmd && wd_expired && !core_start && !core_ack)
            timeout <= 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         nblocks  <= '0;
         count    <= '0;
         irq_en   <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         readdata <= '0;
      end else begin
         readdata <= rd_mux;
         if (ctrl_wr)
            irq_en <= writedata[2];
         // Clears first so a same-cycle hardware set below takes precedence.
         if (stat_wr && writedata[1])
            done <= 1'b0;
         if (stat_wr && writedata[3])
            err <= 1'b0;
         if (nblk_wr) begin
            if (busy)
               err <= 1'b1;
            else
               nblocks <= writedata[CNT_W-1:0];
         end
         if (start_cmd && busy)
            err <= 1'b1;

         case (state)
            IDLE: begin
               if (start_cmd) begin
                  if (nblocks != '0) begin
                     count <= '0;
                     done  <= 1'b0;
                     state <= WAIT_RDY;
                  end else begin
                     done  <= 1'b1;
                  end
               end
            end
            WAIT_RDY: begin
               if (abort_cmd)
                  state <= IDLE;
               else if (core_ready)
                  state <= RUN;
               else if (wd_expired)
                  state <= IDLE;
            end
            RUN: begin
               if (abort_cmd) begin
                  state <= IDLE;
               end else if (core_valid) begin
                  count <= count + 1'b1;
                  if (last_blk) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     state <= WAIT_RDY;
                  end
               end else if (wd_expired) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
